// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: core and debug request ports plus the shared memory port.
// slave is the arbiter's view; master is the requester/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_ready;
  logic [DATA_W-1:0] core_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ready;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_ready, core_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ready, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_ready, core_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ready, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the core and the debug/loader port, one fixed-latency access at a time.
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (debug first).
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic              busy,
  output logic              owner_dbg
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              core_ready_q;
  logic              dbg_ready_q;
  logic              pick_dbg;

`ifdef ARB_RR_EN
  logic last_dbg;

  // On contention the side not granted last time wins; a lone requester always wins.
  assign pick_dbg = bus.dbg_req & (~bus.core_req | ~last_dbg);
`else
  assign pick_dbg = bus.dbg_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      core_ready_q <= 1'b0;
      dbg_ready_q  <= 1'b0;
      busy         <= 1'b0;
      owner_dbg    <= 1'b0;
`ifdef ARB_RR_EN
      last_dbg     <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.core_req | bus.dbg_req) begin
            owner_dbg <= pick_dbg;
            mem_we_q  <= pick_dbg ? bus.dbg_we    : bus.core_we;
            addr_q    <= pick_dbg ? bus.dbg_addr  : bus.core_addr;
            wdata_q   <= pick_dbg ? bus.dbg_wdata : bus.core_wdata;
            cnt       <= CNT_LOAD;
            mem_en_q  <= 1'b1;
            busy      <= 1'b1;
            state     <= ACCESS;
`ifdef ARB_RR_EN
            last_dbg  <= pick_dbg;
`endif
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // mem_we_q still holds the access type during the final access cycle
            if (!mem_we_q) rdata_q <= bus.mem_rdata;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            core_ready_q <= ~owner_dbg;
            dbg_ready_q  <= owner_dbg;
            state        <= RESP;
          end
        end
        RESP: begin
          core_ready_q <= 1'b0;
          dbg_ready_q  <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.core_ready = core_ready_q;
  assign bus.dbg_ready  = dbg_ready_q;
  assign bus.core_rdata = rdata_q;
  assign bus.dbg_rdata  = rdata_q;

endmodule
